// File: rtl/coin_acceptor_frontend_pkg.sv
// Shared types for the coin acceptor front end: coin codes, coin values and
// the output FSM state encoding.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_20   = 2'b11
  } coin_e;

  localparam int unsigned COIN_VAL_5  = 5;
  localparam int unsigned COIN_VAL_10 = 10;
  localparam int unsigned COIN_VAL_20 = 20;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EMIT = 2'b01,
    GAP  = 2'b10
  } out_state_e;

  function automatic logic [4:0] coin_value(coin_e code);
    case (code)
      COIN_5:  return 5'(COIN_VAL_5);
      COIN_10: return 5'(COIN_VAL_10);
      COIN_20: return 5'(COIN_VAL_20);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_acceptor_frontend_if.sv
// Sensor/vending-side bundle of the coin acceptor front end. audit_total is
// present only when COIN_AUDIT_EN is defined.
interface coin_acceptor_frontend_if #(
  parameter int FIFO_DEPTH = 4
);
  import coin_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          coin_raw_5;
  logic          coin_raw_10;
  logic          coin_raw_20;
  logic          hold;
  coin_e         coin_code;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          reject;
`ifdef COIN_AUDIT_EN
  logic [15:0]   audit_total;
`endif

  modport master (
    output coin_raw_5, coin_raw_10, coin_raw_20, hold,
    input  coin_code, fifo_count, overflow, reject
`ifdef COIN_AUDIT_EN
    , input audit_total
`endif
  );

  modport slave (
    input  coin_raw_5, coin_raw_10, coin_raw_20, hold,
    output coin_code, fifo_count, overflow, reject
`ifdef COIN_AUDIT_EN
    , output audit_total
`endif
  );

endinterface

// File: rtl/coin_acceptor_frontend_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and a registered
// rising-edge pulse of the debounced level.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       r_level;
  logic       r_level_d;
  logic       r_rise;

  // NOTE: state updates use <= so every flop samples pre-edge values,
  // regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_cnt     <= 8'd0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      if (r_sync[1] == r_level) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
        r_level <= r_sync[1];
        r_cnt   <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/coin_acceptor_frontend.sv
// Coin sensor conditioning: debounce, one event per coin, FIFO, and a
// single-cycle coin code followed by a gap. COIN_AUDIT_EN adds audit_total.
module coin_acceptor_frontend
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  coin_acceptor_frontend_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    w_rise;
  logic          w_push;
  logic          w_multi;
  coin_e         w_push_code;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  coin_e         w_head;
  out_state_e    w_state_next;

  coin_e         r_mem [FIFO_DEPTH];
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_reject;
  coin_e         r_code;
  out_state_e    r_state;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_5 (
    .clk(clk), .rst_n(rst_n), .i_raw(bus.coin_raw_5),  .o_rise(w_rise[0]));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_10 (
    .clk(clk), .rst_n(rst_n), .i_raw(bus.coin_raw_10), .o_rise(w_rise[1]));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_20 (
    .clk(clk), .rst_n(rst_n), .i_raw(bus.coin_raw_20), .o_rise(w_rise[2]));

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_push      = 1'b0;
    w_multi     = 1'b0;
    w_push_code = COIN_NONE;
    case (w_rise)
      3'b000: ;
      3'b001: begin w_push = 1'b1; w_push_code = COIN_5;  end
      3'b010: begin w_push = 1'b1; w_push_code = COIN_10; end
      3'b100: begin w_push = 1'b1; w_push_code = COIN_20; end
      default: w_multi = 1'b1;
    endcase
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == CW'(FIFO_DEPTH));
  assign w_empty = (w_count == '0);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  // A pop frees the head slot on the same edge, so a full FIFO still accepts.
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!bus.hold && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = EMIT;
        end
      end
      EMIT:    w_state_next = GAP;
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_code     <= COIN_NONE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_code   <= w_pop ? w_head : COIN_NONE;
      r_reject <= w_multi;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + CW'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are
  // valid, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_push_code;
  end

  assign bus.coin_code  = r_code;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_overflow;
  assign bus.reject     = r_reject;

`ifdef COIN_AUDIT_EN
  logic [15:0] r_audit;
  logic [16:0] w_audit_sum;

  assign w_audit_sum = {1'b0, r_audit} + 17'(coin_value(r_code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_audit <= 16'd0;
    else        r_audit <= w_audit_sum[16] ? 16'hFFFF : w_audit_sum[15:0];
  end

  assign bus.audit_total = r_audit;
`endif

endmodule

// File: doc/coin_acceptor_frontend.md
Name: coin_acceptor_frontend

Overview:
Conditions the three raw coin-sensor lines (5, 10 and 20 units) before they reach the vending FSM.
- Synchronises and debounces each line.
- Detects one insertion event per coin and queues events in a small FIFO.
- Emits each coin as a single-cycle 2-bit coin code followed by a mandatory idle gap, because the vending FSM adds value on every cycle its code is non-zero.
- Holds queued coins while the vending FSM is dispensing.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised line must hold a new level before the debounced level changes; legal range 1..255.
- FIFO_DEPTH, 4: coin-event queue entries; must be a power of 2, at least 2.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- coin_raw_5, input, 1: raw sensor, 5-unit coin, asynchronous to clk.
- coin_raw_10, input, 1: raw sensor, 10-unit coin.
- coin_raw_20, input, 1: raw sensor, 20-unit coin.
- hold, input, 1: downstream busy (vending FSM in dispense state); blocks new emissions.
- coin_code, output, 2: 00 none, 01 = 5, 10 = 10, 11 = 20; non-zero for exactly one cycle per coin.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: queued events.
- overflow, output, 1: sticky; set when an event is dropped because the FIFO is full.
- reject, output, 1: one-cycle pulse when two or more channels produce a debounced rising edge in the same cycle.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n is low:
  - all synchroniser flops, debounce counters, debounced levels, FIFO pointers and the output FSM clear;
  - coin_code = 00, fifo_count = 0, overflow = 0, reject = 0.
  - Reset asserted mid-operation discards queued coins and any in-flight emission.
- Synchroniser: two flops per channel.
- Debounce, per channel:
  - Counter increments while the synchronised level differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Event: a rising edge of a debounced level, registered one cycle after the level changes.
  - Exactly one channel rising: push its code into the FIFO.
  - Two or more channels rising in the same cycle: no push; reject pulses for one cycle.
- FIFO:
  - Push when full: event dropped, overflow set; overflow clears only on reset.
  - Push and pop in the same cycle: both take effect, including when full (count unchanged, no overflow).
  - Pointers wrap modulo FIFO_DEPTH.
- Output FSM, states IDLE, EMIT, GAP:
  - IDLE → EMIT when hold = 0 and the FIFO is not empty. The head is popped on this edge and coin_code is registered from it.
  - EMIT: coin_code = head value for exactly one cycle; always → GAP.
  - GAP: coin_code = 00; → IDLE after one cycle.
  - hold is sampled only in IDLE. An EMIT already entered completes even if hold rises during it.
  - Back-to-back coins are therefore spaced at least 3 cycles apart.
- Latency: raw rise first sampled at edge N, FIFO empty, hold = 0 → coin_code non-zero in the cycle after edge N+DEBOUNCE_CYCLES+4 (edge N+8 with the default).
- Width rules: coin_code is taken directly from the 2-bit encoding, with no arithmetic. fifo_count is the full-width pointer difference.

Optional Feature:
COIN_AUDIT_EN.
- Defined: adds a 16-bit output audit_total. It accumulates the value (5/10/20) of each coin in the cycle it is emitted, saturates at 16'hFFFF, and clears on reset only.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package coin_pkg holds:
  - the coin code enum (COIN_NONE = 2'b00, COIN_5 = 2'b01, COIN_10 = 2'b10, COIN_20 = 2'b11);
  - the coin value constants (5, 10, 20);
  - the output FSM state typedef (IDLE, EMIT, GAP).
- Sub-module coin_debounce: the 2-flop synchroniser plus debounce counter plus registered rising-edge detect, instantiated once per channel.

Test Plan:
1. coin_raw_10 high for 20 cycles, hold = 0, DEBOUNCE_CYCLES = 4 → coin_code = 10 for exactly one cycle, 9 cycles after the first sampling edge; reject = 0; fifo_count returns to 0.
2. coin_raw_5 pulsed high for 3 cycles (shorter than the debounce window) → coin_code stays 00 and fifo_count stays 0.
3. hold = 1, then three coins inserted (5, 20, 10) → fifo_count = 3, coin_code stays 00. Release hold → codes 01, 11, 10 in order, each a single cycle, 3 cycles apart.
4. hold = 1, then 5 coins inserted with FIFO_DEPTH = 4 → fifo_count = 4, overflow = 1. After release exactly 4 codes are emitted; overflow stays 1 until reset.
5. coin_raw_5 and coin_raw_20 rise on the same edge → one reject pulse, no push, coin_code stays 00.
6. rst_n asserted while in EMIT with 2 coins queued → coin_code = 00 and fifo_count = 0 immediately. After release no stale codes are emitted. With COIN_AUDIT_EN defined, audit_total = 0.
